pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It watches the ID, ID/EX and EX/MEM stage fields and produces the write-enable, bubble and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers three cases: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory accesses, which use a req/ready handshake with a timeout. It also keeps saturating stall and flush counters.

## Interface
- MEM_TIMEOUT, 15: maximum MEM_WAIT cycles before an access is aborted; legal range 1..255.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_ID_rs1, IF_ID_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- ID_EX_MemRead  in  1  the instruction in EX is a load.
- ID_EX_rd  in  5  destination register of the instruction in EX.
- EX_MEM_branch, EX_MEM_zero  in  1 each  branch flag and zero flag of the instruction in MEM.
- EX_MEM_branch_target  in  8  branch target of the instruction in MEM.
- EX_MEM_MemRead, EX_MEM_MemWrite  in  1 each  memory op in MEM.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data memory access request.
- PCsrc  out  1  taken branch; selects pc_target; flushes EX/MEM.
- pc_target  out  8  equals EX_MEM_branch_target.
- pc_write, IF_ID_write  out  1 each  register enables.
- IF_ID_flush, ID_EX_bubble  out  1 each  zero the register contents on the next edge.
- ID_EX_hold, EX_MEM_hold  out  1 each  freeze the register contents.
- MEM_WB_bubble  out  1  write a NOP into MEM/WB.
- state  out  1  0=RUN, 1=MEM_WAIT.
- mem_err  out  1  sticky flag: a timeout has occurred.
- stall_count, flush_count  out  16 each  saturating performance counters.

## Operation
- Definitions:
  - mem_op = EX_MEM_MemRead | EX_MEM_MemWrite.
  - taken = EX_MEM_branch & EX_MEM_zero.
  - lu = ID_EX_MemRead & ID_EX_rd≠0 & (ID_EX_rd==IF_ID_rs1 | (id_uses_rs2 & ID_EX_rd==IF_ID_rs2)).
- dmem_req = mem_op while in RUN. In MEM_WAIT it stays 1 until completion or timeout.
- mstall = dmem_req & !dmem_ready & !timeout_now.
  - Effect: pc_write=0, IF_ID_write=0, ID_EX_hold=1, EX_MEM_hold=1, MEM_WB_bubble=1, ID_EX_bubble=0, IF_ID_flush=0.
- Taken branch (not mstall): PCsrc=1, IF_ID_flush=1, ID_EX_bubble=1, pc_write=1.
- Load-use (not mstall, not taken): pc_write=0, IF_ID_write=0, ID_EX_bubble=1.
- Priority: mstall > taken > lu > normal.
  - taken and mem_op in the same cycle cannot both be legal; if it happens, mstall wins.
- Normal operation: pc_write=1, IF_ID_write=1; all other controls 0.
- FSM:
  - RUN→MEM_WAIT when mem_op & !dmem_ready. wait_cnt is set to 1.
  - MEM_WAIT→RUN on dmem_ready. That cycle is a normal advance.
  - MEM_WAIT: if !dmem_ready and wait_cnt<MEM_TIMEOUT, increment wait_cnt.
  - MEM_WAIT with wait_cnt==MEM_TIMEOUT & !dmem_ready is a timeout (timeout_now=1):
    - dmem_req=0, stalls released, MEM_WB_bubble=1 (access dropped).
    - mem_err←1; next state RUN.
- stall_count increments on every mstall or lu cycle. flush_count increments on every taken cycle. Both saturate at 0xFFFF.

## Timing
- All controls are combinational from inputs and state, with zero latency. Registers act on the next rising edge.
- A zero-wait access (dmem_ready with the request) causes no stall and no MEM_WAIT entry.
- A memory access completed after N wait cycles holds the pipeline for exactly N cycles.
- Load-use inserts exactly one bubble. The next cycle, the load sits in MEM, so lu=0.
- PCsrc is a one-cycle pulse: EX/MEM is zeroed on the following edge.
- Reset (asynchronous, any time, including mid-MEM_WAIT):
  - state=RUN, wait_cnt=0, mem_err=0, counters=0.
  - While rst_n=0, outputs are forced to: dmem_req=0, PCsrc=0, pc_write=0, IF_ID_write=0, all bubble/hold/flush=0.
  - Normal operation resumes on the first edge after release.

## Test plan
- Load x5 in EX, ID reads x5 (rs1) → one cycle with pc_write=0, ID_EX_bubble=1, stall_count=1. With ID_EX_rd=0 → no stall.
- EX_MEM_branch=1, zero=1, target=8'h2C → PCsrc=1, pc_target=8'h2C, IF_ID_flush=1, ID_EX_bubble=1, flush_count=1. Simultaneous lu → branch outputs only, pc_write=1.
- Load in MEM, dmem_ready after 3 cycles → 3 stalled cycles (holds=1, MEM_WB_bubble=1), state=1 for 3 cycles, RUN afterwards, stall_count=3.
- dmem_ready never asserted, MEM_TIMEOUT=4 → MEM_WAIT for 4 cycles, stalls drop on the 4th, mem_err=1 (sticky), state=0.
- rst_n pulled low during MEM_WAIT → immediately state=0, dmem_req=0, counters=0, mem_err=0.
- Drive 70000 load-use cycles → stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MEM-resolved branches, multi-cycle dmem with timeout.
// Controls are combinational (zero latency); FSM, wait counter, error flag and perf counters update on clk.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] IF_ID_rs1,
  input  logic [4:0] IF_ID_rs2,
  input  logic       id_uses_rs2,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_rd,
  input  logic       EX_MEM_branch,
  input  logic       EX_MEM_zero,
  input  logic [7:0] EX_MEM_branch_target,
  input  logic       EX_MEM_MemRead,
  input  logic       EX_MEM_MemWrite,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       PCsrc,
  output logic [7:0] pc_target,
  output logic       pc_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_bubble,
  output logic       ID_EX_hold,
  output logic       EX_MEM_hold,
  output logic       MEM_WB_bubble,
  output logic       state,
  output logic       mem_err,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic        r_mem_err;
  logic [15:0] r_stall_cnt, r_flush_cnt;

  logic w_mem_op, w_taken, w_lu, w_timeout, w_req, w_mstall;
  logic w_stall_cyc, w_flush_cyc;

  assign w_mem_op = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign w_taken  = EX_MEM_branch & EX_MEM_zero;
  assign w_lu     = ID_EX_MemRead & (ID_EX_rd != 5'd0) &
                    ((ID_EX_rd == IF_ID_rs1) | (id_uses_rs2 & (ID_EX_rd == IF_ID_rs2)));

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout      = 1'b0;
    w_req          = 1'b0;
    case (r_state)
      RUN: begin
        w_req = w_mem_op;
        if (w_mem_op && !dmem_ready) begin
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          w_req          = 1'b1;
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = 8'd0;
        end else if (r_wait_cnt == TIMEOUT_C) begin
          // Access is abandoned: request drops and the pipeline is released.
          w_timeout      = 1'b1;
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = 8'd0;
        end else begin
          w_req          = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_mstall    = w_req & ~dmem_ready & ~w_timeout;
  assign w_stall_cyc = w_mstall | (w_lu & ~w_taken);
  assign w_flush_cyc = w_taken & ~w_mstall;

  always_comb begin
    dmem_req      = 1'b0;
    PCsrc         = 1'b0;
    pc_write      = 1'b0;
    IF_ID_write   = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_bubble  = 1'b0;
    ID_EX_hold    = 1'b0;
    EX_MEM_hold   = 1'b0;
    MEM_WB_bubble = 1'b0;
    if (rst_n) begin
      dmem_req      = w_req;
      MEM_WB_bubble = w_timeout;
      if (w_mstall) begin
        ID_EX_hold    = 1'b1;
        EX_MEM_hold   = 1'b1;
        MEM_WB_bubble = 1'b1;
      end else if (w_taken) begin
        PCsrc        = 1'b1;
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
      end else if (w_lu) begin
        ID_EX_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= 8'd0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout)
        r_mem_err <= 1'b1;
      if (w_stall_cyc && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_cyc && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign pc_target   = EX_MEM_branch_target;
  assign state       = r_state;
  assign mem_err     = r_mem_err;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expectations queued at drive time, checked at the falling edge.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic       id_uses_rs2, ID_EX_MemRead;
  logic       EX_MEM_branch, EX_MEM_zero, EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready;
  logic [7:0] EX_MEM_branch_target;
  logic       dmem_req, PCsrc, pc_write, IF_ID_write, IF_ID_flush;
  logic       ID_EX_bubble, ID_EX_hold, EX_MEM_hold, MEM_WB_bubble, state, mem_err;
  logic [7:0] pc_target;
  logic [15:0] stall_count, flush_count;

  int checks = 0;
  int failures = 0;

  // {dmem_req, PCsrc, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_hold, EX_MEM_hold, MEM_WB_bubble}
  localparam logic [8:0] C_NORM = 9'b0_0_1_1_0_0_0_0_0;
  localparam logic [8:0] C_REQ  = 9'b1_0_1_1_0_0_0_0_0;
  localparam logic [8:0] C_LU   = 9'b0_0_0_0_0_1_0_0_0;
  localparam logic [8:0] C_BR   = 9'b0_1_1_1_1_1_0_0_0;
  localparam logic [8:0] C_MS   = 9'b1_0_0_0_0_0_1_1_1;
  localparam logic [8:0] C_TO   = 9'b0_0_1_1_0_0_0_0_1;
  localparam logic [8:0] C_RST  = 9'b0_0_0_0_0_0_0_0_0;

  typedef struct packed {
    logic [8:0]  ctl;
    logic        st;
    logic        err;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [7:0]  tgt;
  } exp_t;

  exp_t exp_q[$];

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .id_uses_rs2(id_uses_rs2),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .EX_MEM_branch(EX_MEM_branch), .EX_MEM_zero(EX_MEM_zero),
    .EX_MEM_branch_target(EX_MEM_branch_target),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .PCsrc(PCsrc), .pc_target(pc_target),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .ID_EX_hold(ID_EX_hold), .EX_MEM_hold(EX_MEM_hold),
    .MEM_WB_bubble(MEM_WB_bubble), .state(state), .mem_err(mem_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rstn, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u2, input logic lr, input logic [4:0] rd,
                       input logic br, input logic z, input logic [7:0] tgt,
                       input logic mr, input logic mw, input logic rdy);
    rst_n = rstn; IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; id_uses_rs2 = u2;
    ID_EX_MemRead = lr; ID_EX_rd = rd; EX_MEM_branch = br; EX_MEM_zero = z;
    EX_MEM_branch_target = tgt; EX_MEM_MemRead = mr; EX_MEM_MemWrite = mw; dmem_ready = rdy;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    logic [8:0] ctl;
    e = exp_q.pop_front();
    ctl = {dmem_req, PCsrc, pc_write, IF_ID_write, IF_ID_flush,
           ID_EX_bubble, ID_EX_hold, EX_MEM_hold, MEM_WB_bubble};
    checks++;
    assert (ctl === e.ctl) else begin
      failures++; $error("FAIL %s ctl got=%b exp=%b", tag, ctl, e.ctl);
    end
    checks++;
    assert (state === e.st) else begin
      failures++; $error("FAIL %s state got=%b exp=%b", tag, state, e.st);
    end
    checks++;
    assert (mem_err === e.err) else begin
      failures++; $error("FAIL %s mem_err got=%b exp=%b", tag, mem_err, e.err);
    end
    checks++;
    assert (stall_count === e.sc) else begin
      failures++; $error("FAIL %s stall_count got=%h exp=%h", tag, stall_count, e.sc);
    end
    checks++;
    assert (flush_count === e.fc) else begin
      failures++; $error("FAIL %s flush_count got=%h exp=%h", tag, flush_count, e.fc);
    end
    checks++;
    assert (pc_target === e.tgt) else begin
      failures++; $error("FAIL %s pc_target got=%h exp=%h", tag, pc_target, e.tgt);
    end
  endtask

  // One directed cycle: drive just after the rising edge, queue the expectation, check at the falling edge.
  task automatic cyc(input string tag, input logic rstn,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                     input logic lr, input logic [4:0] rd,
                     input logic br, input logic z, input logic [7:0] tgt,
                     input logic mr, input logic mw, input logic rdy,
                     input logic [8:0] ectl, input logic est, input logic eerr,
                     input logic [15:0] esc, input logic [15:0] efc);
    @(posedge clk);
    #1;
    drive(rstn, rs1, rs2, u2, lr, rd, br, z, tgt, mr, mw, rdy);
    exp_q.push_back('{ctl: ectl, st: est, err: eerr, sc: esc, fc: efc, tgt: tgt});
    @(negedge clk);
    check_out(tag);
  endtask

  initial begin
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    //   tag        rst rs1 rs2 u2 lr rd  br z  tgt    mr mw rdy  ctl     st err sc  fc
    cyc("reset",    0, 5, 5, 1, 1, 5, 1, 1, 8'h11, 1, 0, 0, C_RST,  0, 0, 0, 0);
    cyc("normal",   1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, C_NORM, 0, 0, 0, 0);
    cyc("lu_rs1",   1, 5, 3, 0, 1, 5, 0, 0, 8'h00, 0, 0, 0, C_LU,   0, 0, 0, 0);
    cyc("zero_wait",1, 5, 3, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, C_REQ,  0, 0, 1, 0);
    cyc("lu_rd0",   1, 0, 0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0, C_NORM, 0, 0, 1, 0);
    cyc("lu_rs2",   1, 1, 7, 1, 1, 7, 0, 0, 8'h00, 0, 0, 0, C_LU,   0, 0, 1, 0);
    cyc("rs2_unused",1,1, 7, 0, 1, 7, 0, 0, 8'h00, 0, 0, 0, C_NORM, 0, 0, 2, 0);
    cyc("taken",    1, 0, 0, 0, 0, 0, 1, 1, 8'h2C, 0, 0, 0, C_BR,   0, 0, 2, 0);
    cyc("not_taken",1, 0, 0, 0, 0, 0, 1, 0, 8'h40, 0, 0, 0, C_NORM, 0, 0, 2, 1);
    cyc("taken_lu", 1, 9, 0, 0, 1, 9, 1, 1, 8'h2C, 0, 0, 0, C_BR,   0, 0, 2, 1);
    cyc("after_br", 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, C_NORM, 0, 0, 2, 2);
    cyc("wait_0",   1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, C_MS,   0, 0, 2, 2);
    cyc("wait_1",   1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, C_MS,   1, 0, 3, 2);
    cyc("wait_2",   1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, C_MS,   1, 0, 4, 2);
    cyc("wait_done",1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, C_REQ,  1, 0, 5, 2);
    cyc("wait_run", 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, C_NORM, 0, 0, 5, 2);
    cyc("to_0",     1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, C_MS,   0, 0, 5, 2);
    cyc("to_1",     1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, C_MS,   1, 0, 6, 2);
    cyc("to_2",     1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, C_MS,   1, 0, 7, 2);
    cyc("to_3",     1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, C_MS,   1, 0, 8, 2);
    cyc("to_fire",  1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, C_TO,   1, 0, 9, 2);
    cyc("to_after", 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, C_NORM, 0, 1, 9, 2);
    cyc("ms_taken", 1, 0, 0, 0, 0, 0, 1, 1, 8'h33, 1, 0, 0, C_MS,   0, 1, 9, 2);
    cyc("ms_wait",  1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, C_MS,   1, 1, 10, 2);
    cyc("rst_mid",  0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, C_RST,  0, 0, 0, 0);
    cyc("rst_rel",  1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, C_NORM, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (70000) @(posedge clk);
    cyc("sat_lu",   1, 5, 0, 0, 1, 5, 0, 0, 8'h00, 0, 0, 0, C_LU,   0, 0, 16'hFFFF, 0);
    cyc("sat_hold", 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, C_NORM, 0, 0, 16'hFFFF, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
